// File: rtl/conv_seq_mac.sv
// Streaming 1-D convolution / cross-correlation engine: loads f then g serially,
// then produces all 2*LEN-1 outputs with a single shared multiply-accumulate.
//
// state  | meaning
// IDLE   | one cycle after reset release, not accepting samples
// LOAD   | accepting f[0..LEN-1] then g[0..LEN-1]
// CALC   | one MAC per cycle for output index k, i = 0..LEN-1
// OUT    | result held on Dout until the consumer takes it
module conv_seq_mac #(
    parameter int LEN = 8,
    parameter int DW  = 4,
    parameter int OW  = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [DW-1:0] Din,
    input  logic          mode,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] Dout
);

    localparam int IW = $clog2(LEN);
    localparam int KW = $clog2(2*LEN-1);
    localparam int XW = KW + 2;
    localparam logic [XW-1:0] LEN_X   = XW'(LEN);
    localparam logic [XW-1:0] LENM1_X = XW'(LEN-1);
    localparam logic [IW-1:0] I_LAST  = IW'(LEN-1);
    localparam logic [KW-1:0] K_LAST  = KW'(2*LEN-2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t state, state_nxt;

    logic [DW-1:0] f [LEN];
    logic [DW-1:0] g [LEN];
    logic [IW-1:0] idx;
    logic          sel_g;
    logic          mode_r;
    logic [KW-1:0] k;
    logic [IW-1:0] i;
    logic [OW-1:0] acc;

    logic          accept, last_sample, mac_last, hs;
    logic [XW-1:0] k_x, i_x, diff, sum, corr_idx;
    logic          g_ok;
    logic [IW-1:0] g_idx;
    logic [2*DW-1:0] prod;
    logic [OW-1:0] term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last_sample = 1'b0;
        mac_last    = 1'b0;
        hs          = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_LOAD;
            S_LOAD: begin
                if (in_en) begin
                    accept = 1'b1;
                    if (sel_g && idx == I_LAST) begin
                        last_sample = 1'b1;
                        state_nxt   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (i == I_LAST) begin
                    mac_last  = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    hs        = 1'b1;
                    state_nxt = (k == K_LAST) ? S_LOAD : S_CALC;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_LOAD);
    assign out_valid = (state == S_OUT);

    // conv reads g[k-i], corr reads g[i+k-(LEN-1)]; anything outside 0..LEN-1 adds zero
    always_comb begin
        k_x      = XW'(k);
        i_x      = XW'(i);
        diff     = k_x - i_x;
        sum      = k_x + i_x;
        corr_idx = sum - LENM1_X;
        if (mode_r) begin
            g_ok  = (sum >= LENM1_X) && (corr_idx < LEN_X);
            g_idx = corr_idx[IW-1:0];
        end else begin
            g_ok  = (k_x >= i_x) && (diff < LEN_X);
            g_idx = diff[IW-1:0];
        end
        prod = (2*DW)'(f[i]) * (2*DW)'(g[g_idx]);
        term = g_ok ? OW'(prod) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < LEN; j++) begin
                f[j] <= '0;
                g[j] <= '0;
            end
            idx    <= '0;
            sel_g  <= 1'b0;
            mode_r <= 1'b0;
            k      <= '0;
            i      <= '0;
            acc    <= '0;
            Dout   <= '0;
        end else begin
            if (accept) begin
                if (sel_g) g[idx] <= Din;
                else       f[idx] <= Din;
                if (!sel_g && idx == '0) mode_r <= mode;
                if (idx == I_LAST) begin
                    idx   <= '0;
                    sel_g <= ~sel_g;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (last_sample) begin
                k   <= '0;
                i   <= '0;
                acc <= '0;
            end
            if (state == S_CALC) begin
                if (mac_last) begin
                    Dout <= acc + term;
                end else begin
                    i   <= i + 1'b1;
                    acc <= acc + term;
                end
            end
            if (hs) begin
                Dout <= '0;
                if (k != K_LAST) begin
                    k   <= k + 1'b1;
                    acc <= '0;
                    i   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_mac.sv
// Directed bench for conv_seq_mac: frames are loaded, expected outputs queued
// from a reference model, then popped and compared as the DUT emits them.
module tb_conv_seq_mac;

    localparam int LEN = 8;
    localparam int DW  = 4;
    localparam int OW  = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_en = 1'b0;
    logic [DW-1:0] Din = '0;
    logic          mode = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [OW-1:0] Dout;

    always #5 clk = ~clk;

    conv_seq_mac #(.LEN(LEN), .DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .Din       (Din),
        .mode      (mode),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Dout      (Dout)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int f_v[LEN];
    int g_v[LEN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input bit m);
        for (int kk = 0; kk < 2*LEN-1; kk++) begin
            int acc_m;
            acc_m = 0;
            for (int ii = 0; ii < LEN; ii++) begin
                int jj;
                jj = m ? (ii + kk - (LEN-1)) : (kk - ii);
                if (jj >= 0 && jj < LEN) acc_m += f_v[ii] * g_v[jj];
            end
            exp_q.push_back(acc_m);
        end
    endtask

    task automatic load_frame(input bit m, input int gap);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("load_ready", {31'd0, busy}, 32'd0);
        for (int s = 0; s < 2*LEN; s++) begin
            in_en = 1'b1;
            Din   = (s < LEN) ? DW'(f_v[s]) : DW'(g_v[s-LEN]);
            mode  = (s == 0) ? m : ~m;
            @(negedge clk);
            in_en = 1'b0;
            if (s < 2*LEN-1) begin
                check($sformatf("busy_load_s%0d", s), {31'd0, busy}, 32'd0);
                for (int gp = 0; gp < gap; gp++) begin
                    @(negedge clk);
                    check($sformatf("busy_gap_s%0d", s), {31'd0, busy}, 32'd0);
                end
            end
        end
        check("busy_after_last", {31'd0, busy}, 32'd1);
        push_expected(m);
    endtask

    task automatic collect_frame(input int stall_k, input int abort_k);
        int cyc;
        int exp_v;
        logic [OW-1:0] held;
        for (int kk = 0; kk < 2*LEN-1; kk++) begin
            if (kk == abort_k) begin
                repeat (3) @(negedge clk);
                reset = 1'b1;
                #1;
                check("abort_busy", {31'd0, busy}, 32'd1);
                check("abort_valid", {31'd0, out_valid}, 32'd0);
                check("abort_dout", 32'(Dout), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                check("abort_idle_busy", {31'd0, busy}, 32'd1);
                exp_q.delete();
                return;
            end
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 4*LEN) begin
                if (cyc == 1) check($sformatf("dout_zero_k%0d", kk), 32'(Dout), 32'd0);
                @(negedge clk);
                cyc++;
            end
            check($sformatf("latency_k%0d", kk), 32'(cyc), 32'(LEN));
            check("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check($sformatf("dout_k%0d", kk), 32'(Dout), 32'(exp_v));
            if (kk == stall_k) begin
                held = Dout;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_dout", 32'(Dout), 32'(held));
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("hs_valid_low", {31'd0, out_valid}, 32'd0);
            check("hs_dout_zero", 32'(Dout), 32'd0);
        end
        check("frame_end_busy", {31'd0, busy}, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_all(input int fv, input int gv);
        for (int j = 0; j < LEN; j++) begin
            f_v[j] = fv;
            g_v[j] = gv;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dout", 32'(Dout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("load_busy", {31'd0, busy}, 32'd0);

        // all ones, convolution
        set_all(1, 1);
        load_frame(1'b0, 0);
        collect_frame(-1, -1);

        // full-scale samples
        set_all(15, 15);
        load_frame(1'b0, 0);
        collect_frame(-1, -1);

        // ramp against impulse: correlation then convolution
        for (int j = 0; j < LEN; j++) begin
            f_v[j] = j + 1;
            g_v[j] = (j == 0) ? 1 : 0;
        end
        load_frame(1'b1, 0);
        collect_frame(-1, -1);
        load_frame(1'b0, 0);
        collect_frame(-1, -1);

        // consumer stall at k=3
        set_all(1, 1);
        load_frame(1'b0, 0);
        collect_frame(3, -1);

        // gapped loading
        load_frame(1'b0, 2);
        collect_frame(-1, -1);

        // reset mid-frame, then a clean frame
        load_frame(1'b0, 0);
        collect_frame(-1, 5);
        load_frame(1'b0, 0);
        collect_frame(-1, -1);

        // spot values independent of the model
        set_all(15, 15);
        load_frame(1'b0, 0);
        check("spot_q_k0", 32'(exp_q[0]), 32'd225);
        check("spot_q_k7", 32'(exp_q[7]), 32'd1800);
        collect_frame(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
